// File: rtl/uart_receiver_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_receiver_if : line-side inputs and host-side results of uart_receiver |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
interface uart_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic                 sample_enable;
    logic                 rx_en;
    logic                 rxd;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ferror;
    logic                 rx_perror;
    logic                 rx_busy;

    modport master (
        output sample_enable, rx_en, rxd,
        input  rx_data, rx_valid, rx_ferror, rx_perror, rx_busy
    );

    modport slave (
        input  sample_enable, rx_en, rxd,
        output rx_data, rx_valid, rx_ferror, rx_perror, rx_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_receiver : oversampled UART receive stage, LSB-first, valid pulse    |
// | Optional even parity: define UART_RX_PARITY_EN.       Revision 1.0        |
// +--------------------------------------------------------------------------+
module uart_receiver #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  wire logic      clk,
    input  wire logic      reset,
    uart_receiver_if.slave bus
);
    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] AFTER_DATA = PARITY;
`else
    localparam logic [2:0] AFTER_DATA = STOP;
`endif

    logic                 sync1, sync2;
    logic                 rxd_s;
    logic [2:0]           state, next_state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bcnt;
    logic [DATA_BITS-1:0] shift;
    logic                 armed;
    logic                 start_det, mid_start, bit_tick, last_bit, stop_tick;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= bus.rxd;
            sync2 <= sync1;
        end
    end
    assign rxd_s = sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Every strobe-qualified event is also gated by rx_en so a disable cycle never acts.
    always_comb begin
        start_det   = bus.rx_en && bus.sample_enable && armed && !rxd_s && (state == IDLE);
        mid_start   = bus.rx_en && bus.sample_enable && (state == START) && (cnt == CNT_MID);
        bit_tick    = bus.rx_en && bus.sample_enable && (cnt == CNT_LAST);
        last_bit    = (bcnt == BIT_LAST);
        stop_tick   = bit_tick && (state == STOP);
        bus.rx_busy = (state != IDLE);
    end

    always_comb begin
        next_state = state;
        if (!bus.rx_en) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_det) next_state = START;
                START:   if (mid_start) next_state = rxd_s ? IDLE : DATA;
                DATA:    if (bit_tick && last_bit) next_state = AFTER_DATA;
`ifdef UART_RX_PARITY_EN
                PARITY:  if (bit_tick) next_state = STOP;
`endif
                STOP:    if (bit_tick) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt           <= '0;
            bcnt          <= '0;
            shift         <= '0;
            armed         <= 1'b1;
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.rx_ferror <= 1'b0;
            bus.rx_perror <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit       <= 1'b0;
`endif
        end else begin
            bus.rx_valid <= 1'b0;
            if (bus.sample_enable && rxd_s) armed <= 1'b1;

            if ((state == IDLE) || !bus.rx_en) begin
                cnt   <= '0;
                bcnt  <= '0;
                shift <= '0;
            end else if (bus.sample_enable) begin
                if (mid_start || (cnt == CNT_LAST)) cnt <= '0;
                else                                cnt <= cnt + 1'b1;

                if ((state == DATA) && bit_tick) begin
                    shift[bcnt] <= rxd_s;
                    bcnt        <= last_bit ? '0 : bcnt + 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                if ((state == PARITY) && bit_tick) par_bit <= rxd_s;
`endif
                if (stop_tick) begin
                    bus.rx_data   <= shift;
                    bus.rx_ferror <= !rxd_s;
`ifdef UART_RX_PARITY_EN
                    bus.rx_perror <= (^shift) ^ par_bit;
`else
                    bus.rx_perror <= 1'b0;
`endif
                    bus.rx_valid  <= 1'b1;
                    // A low stop bit means the line may be stuck low; wait for idle before re-arming.
                    if (!rxd_s) armed <= 1'b0;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// Randomised bench for uart_receiver: frames are driven bit-by-bit and the
// expected results are queued from the frame contents and popped on rx_valid.
module tb_uart_receiver;
    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;
    localparam int SE_DIV     = 4;
    localparam int BIT_CLKS   = OVERSAMPLE * SE_DIV;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    uart_receiver_if #(.DATA_BITS(DATA_BITS)) bus();

    uart_receiver #(
        .OVERSAMPLE(OVERSAMPLE),
        .DATA_BITS (DATA_BITS)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       ferror;
        logic       perror;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks   = 0;
    int         n_errors   = 0;
    logic [7:0] last_data  = 8'h00;
    bit         prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int ph;
        ph = 0;
        bus.sample_enable = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % SE_DIV;
            bus.sample_enable = (ph == 0);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rx_valid) begin
                check("valid_width", {31'b0, prev_valid}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {31'b0, bus.rx_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rx_data",   {24'b0, bus.rx_data},   {24'b0, e.data});
                    check("rx_ferror", {31'b0, bus.rx_ferror}, {31'b0, e.ferror});
                    check("rx_perror", {31'b0, bus.rx_perror}, {31'b0, e.perror});
                end
            end
            prev_valid = bus.rx_valid;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // abort: 0 none, 1 reset during data bit 4, 2 rx_en dropped during data bit 4
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_flip,
                              input int abort);
        exp_t e;
        logic par;
        par = (^d) ^ par_flip;
        if (abort == 0) begin
            e.data   = d;
            e.ferror = !stop_ok;
`ifdef UART_RX_PARITY_EN
            e.perror = (^d) ^ par;
`else
            e.perror = 1'b0;
`endif
            exp_q.push_back(e);
            last_data = d;
        end
        bus.rxd = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < DATA_BITS; i++) begin
            bus.rxd = d[i];
            if (abort != 0 && i == 4) begin
                wait_clks(BIT_CLKS / 2);
                if (abort == 1) begin
                    reset = 1'b1;
                    #1;
                    check("abort_rst_busy",  {31'b0, bus.rx_busy},  32'd0);
                    check("abort_rst_valid", {31'b0, bus.rx_valid}, 32'd0);
                    check("abort_rst_data",  {24'b0, bus.rx_data},  32'd0);
                    last_data = 8'h00;
                    wait_clks(3);
                    bus.rxd = 1'b1;
                    reset   = 1'b0;
                end else begin
                    bus.rx_en = 1'b0;
                    wait_clks(1);
                    check("abort_en_busy", {31'b0, bus.rx_busy}, 32'd0);
                    check("abort_en_held", {24'b0, bus.rx_data}, {24'b0, last_data});
                    bus.rxd = 1'b1;
                    wait_clks(8);
                    bus.rx_en = 1'b1;
                end
                wait_clks(2 * BIT_CLKS);
                return;
            end
            wait_clks(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        bus.rxd = par;
        wait_clks(BIT_CLKS);
`endif
        if (stop_ok) begin
            bus.rxd = 1'b1;
            wait_clks(BIT_CLKS);
        end else begin
            bus.rxd = 1'b0;
            wait_clks(3 * BIT_CLKS);
            check("ferr_no_restart", {31'b0, bus.rx_busy}, 32'd0);
            bus.rxd = 1'b1;
            wait_clks(BIT_CLKS);
        end
    endtask

    task automatic drain(input string tag);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 4 * BIT_CLKS) begin
            wait_clks(1);
            i++;
        end
        check(tag, exp_q.size(), 32'd0);
    endtask

    initial begin
        logic seen_busy, seen_other;
        logic [7:0] rd;
        bus.rxd   = 1'b1;
        bus.rx_en = 1'b1;
        #2 reset = 1'b1;
        wait_clks(3);
        check("reset_data",   {24'b0, bus.rx_data},   32'd0);
        check("reset_valid",  {31'b0, bus.rx_valid},  32'd0);
        check("reset_ferror", {31'b0, bus.rx_ferror}, 32'd0);
        check("reset_perror", {31'b0, bus.rx_perror}, 32'd0);
        check("reset_busy",   {31'b0, bus.rx_busy},   32'd0);
        reset = 1'b0;

        seen_busy  = 1'b0;
        seen_other = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            wait_clks(1);
            seen_busy  = seen_busy | bus.rx_busy;
            seen_other = seen_other | bus.rx_valid | bus.rx_ferror | bus.rx_perror | (|bus.rx_data);
        end
        check("idle_busy",    {31'b0, seen_busy},  32'd0);
        check("idle_outputs", {31'b0, seen_other}, 32'd0);

        send_frame(8'hA5, 1'b1, 1'b0, 0);
        drain("drain_a5");
        wait_clks(200);
        check("held_a5", {24'b0, bus.rx_data}, 32'h0000_00A5);

        bus.rxd = 1'b0;
        wait_clks(5 * SE_DIV);
        bus.rxd = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("glitch_busy", {31'b0, bus.rx_busy}, 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0, 0);
        drain("drain_3c");

        send_frame(8'h55, 1'b0, 1'b0, 0);
        drain("drain_55");
        send_frame(8'h81, 1'b1, 1'b0, 0);
        drain("drain_81");

        send_frame(8'h00, 1'b1, 1'b0, 0);
        send_frame(8'hFF, 1'b1, 1'b0, 0);
        send_frame(8'h12, 1'b1, 1'b0, 0);
        drain("drain_b2b");

        send_frame(8'hC3, 1'b1, 1'b0, 1);
        send_frame(8'h6E, 1'b1, 1'b0, 2);
        send_frame(8'h99, 1'b1, 1'b0, 0);
        drain("drain_after_abort");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b1, 0);
        drain("drain_bad_parity");
`endif

        for (int k = 0; k < 6; k++) begin
            rd = 8'($urandom_range(0, 255));
            wait_clks($urandom_range(0, 2 * BIT_CLKS));
            send_frame(rd, 1'b1, 1'b0, 0);
        end
        drain("drain_random");
        wait_clks(100);
        check("held_final", {24'b0, bus.rx_data}, {24'b0, last_data});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage that sits directly downstream of the baud-rate controller. It consumes the oversampling strobe, synchronises the asynchronous `rxd` line, and detects and qualifies start bits. It assembles LSB-first data words and presents each received byte with a one-cycle valid pulse and error flags to the host-side logic.

## Interface
- `OVERSAMPLE`, 16: `sample_enable` strobes per bit period; even, ≥ 4.
- `DATA_BITS`, 8: data bits per frame (1..8).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high; clock `clk`.
- `sample_enable` in 1: single-`clk`-cycle strobe, OVERSAMPLE × baud rate.
- `rx_en` in 1: receiver enable; low forces idle.
- `rxd` in 1: asynchronous serial line, idle high.
- `rx_data` out DATA_BITS: last received word, held until the next completed frame.
- `rx_valid` out 1: one-`clk` pulse when `rx_data` and the flags update.
- `rx_ferror` out 1: framing error (stop bit sampled low), qualified by `rx_valid`, held with `rx_data`.
- `rx_perror` out 1: parity error, qualified by `rx_valid`, held with `rx_data`. Tied 0 without parity.
- `rx_busy` out 1: high in any state other than IDLE.

## Operation
- `rxd` passes through a 2-FF synchroniser (`rxd_s`) before any use. All sampling uses `rxd_s`.
- Strobe counter `cnt` is $clog2(OVERSAMPLE) bits wide. It advances only on `sample_enable`, and wraps at OVERSAMPLE-1 → 0.
- Bit counter `bcnt` counts 0..DATA_BITS-1.
- `armed` flag:
  - Cleared after a framing error.
  - Set on any strobe with `rxd_s`=1.
  - Start detection requires `armed`=1.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: on a strobe with `rx_en`=1, `armed`=1 and `rxd_s`=0, go to START with `cnt`=0.
- START: on the strobe where `cnt`=OVERSAMPLE/2-1 (mid start bit), check `rxd_s`.
  - `rxd_s`=1: glitch; return to IDLE with no output.
  - `rxd_s`=0: go to DATA with `cnt`=0 and `bcnt`=0.
- DATA: on each strobe where `cnt`=OVERSAMPLE-1, shift `rxd_s` into the shift register, LSB first. After bit DATA_BITS-1, go to PARITY or STOP with `cnt`=0.
- PARITY: at `cnt`=OVERSAMPLE-1, sample the parity bit. Go to STOP.
- STOP: at `cnt`=OVERSAMPLE-1, sample the stop bit, then return to IDLE.
  - Load `rx_data` from the shift register.
  - Set `rx_ferror` to NOT(`rxd_s`).
  - Set `rx_perror` per Configuration.
  - Assert `rx_valid`.
  - If the stop bit was 0, clear `armed`.
- `rx_en` low in any state: go to IDLE on the next `clk`. No `rx_valid`; held outputs unchanged; shift register discarded.
- The FSM ignores a `sample_enable` asserted in consecutive cycles as no special case; each high cycle counts as one strobe.

## Timing
- Reset values:
  - `rx_data`=0, `rx_valid`=0, `rx_ferror`=0, `rx_perror`=0, `rx_busy`=0.
  - FSM=IDLE, `cnt`=0, `bcnt`=0.
  - `armed`=1, synchroniser FFs=1.
- `rxd` → `rxd_s` latency: 2 `clk`.
- `rx_valid` rises on the `clk` edge that processes the stop-sample strobe. It stays high for exactly 1 `clk`.
- Next start detection is possible from the first strobe after that edge (back-to-back frames supported).
- Nominal frame length from the start-detect strobe to the stop sample, in strobes:
  - Without parity: OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE.
  - With parity: add OVERSAMPLE.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous). No `rx_valid` is produced for the partial frame.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is present.
  - The frame carries one even-parity bit after the data.
  - `rx_perror` = XOR of the received data bits and the parity bit.
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state; STOP follows the data directly.
  - `rx_perror` is constant 0.

## Test plan
- Bench setup for all scenarios: OVERSAMPLE=16, DATA_BITS=8, `sample_enable` every 4 `clk`.
- Reset then idle line: all outputs 0, `rx_busy`=0 for 1000 `clk`.
- Frame 0xA5, correct stop (and correct even parity when `UART_RX_PARITY_EN` is defined) → single `rx_valid` pulse; `rx_data`=0xA5, `rx_ferror`=0, `rx_perror`=0. `rx_data` held afterwards.
- Start glitch: `rxd` low for 5 strobes then high → return to IDLE, no `rx_valid`. A subsequent 0x3C frame is received correctly.
- Stop bit driven 0 on a 0x55 frame, line held low 3 bit-times → `rx_valid` with `rx_ferror`=1 and `rx_data`=0x55. No new start until the line returns high; then 0x81 is received cleanly.
- Back-to-back 0x00, 0xFF, 0x12 with no idle gap → three `rx_valid` pulses carrying 0x00, 0xFF, 0x12 in order.
- `reset` asserted at data bit 4, and `rx_en` dropped at data bit 4 (separate runs) → no `rx_valid`, `rx_busy`=0 within 1 `clk`. With parity enabled, a 0x01 frame with parity bit 0 gives `rx_perror`=1.
